// File: rtl/ubfly_s2b.sv
// rtl/ubfly_s2b.sv - stochastic-to-binary converter for butterfly bitstreams
// Counts ones on four streams over 2^BITWIDTH enabled cycles and hands out saturated counts.
module ubfly_s2b #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iStart,
  input  logic                iReal0,
  input  logic                iImg0,
  input  logic                iReal1,
  input  logic                iImg1,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oReal0,
  output logic [BITWIDTH-1:0] oImg0,
  output logic [BITWIDTH-1:0] oReal1,
  output logic [BITWIDTH-1:0] oImg1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [BITWIDTH:0] LAST_SAMPLE = (BITWIDTH+1)'((1 << BITWIDTH) - 1);

  logic [1:0]                     state_q, state_d;
  logic [BITWIDTH:0]              cyc_q, cyc_d;
  logic [3:0][BITWIDTH:0]         cnt_q, cnt_d;
  logic [3:0][BITWIDTH-1:0]       out_q, out_d;
  logic                           valid_q, valid_d;
  logic [3:0]                     bits;

  // A full window of ones yields N, which does not fit; clamp to all-ones.
  function automatic logic [BITWIDTH-1:0] sat(input logic [BITWIDTH:0] c);
    return c[BITWIDTH] ? {BITWIDTH{1'b1}} : c[BITWIDTH-1:0];
  endfunction

  assign bits = {iImg1, iReal1, iImg0, iReal0};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_ACCUM;
          cyc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (iEn) begin
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i] + {{BITWIDTH{1'b0}}, bits[i]};
          end
          cyc_d = cyc_q + 1'b1;
          if (cyc_q == LAST_SAMPLE) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
              out_d[i] = sat(cnt_d[i]);
            end
          end
        end
      end
      S_DONE: begin
        if (valid_q && iReady) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (iClr) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      cnt_d   = '0;
      out_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign oBusy  = (state_q == S_ACCUM);
  assign oValid = valid_q;
  assign oReal0 = out_q[0];
  assign oImg0  = out_q[1];
  assign oReal1 = out_q[2];
  assign oImg1  = out_q[3];

endmodule

// File: doc/ubfly_s2b.md
UBFLY_S2B -- requirements
Module: ubfly_s2b

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8, which sets the window length N = 2^BITWIDTH enabled cycles and the result width.
REQ-002 Port iClk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port iEn, input, 1 bit: sample enable; a cycle counts toward the window only when iEn=1.
REQ-005 Port iClr, input, 1 bit: synchronous abort and clear.
REQ-006 Port iStart, input, 1 bit: pulse that starts one conversion window.
REQ-007 Ports iReal0, iImg0, iReal1, iImg1, inputs, 1 bit each: butterfly output bitstreams.
REQ-008 Port iReady, input, 1 bit: downstream accepts the result.
REQ-009 Port oBusy, output, 1 bit: high in the ACCUM state.
REQ-010 Port oValid, output, 1 bit: result available.
REQ-011 Ports oReal0, oImg0, oReal1, oImg1, outputs, BITWIDTH bits each: unsigned ones-counts for each stream.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and DONE; reset state is IDLE.
REQ-013 IDLE -> ACCUM SHALL occur on iStart=1; in that cycle the four ones-counters and the cycle counter SHALL be zeroed, and the cycle's stream bits SHALL NOT be counted.
REQ-014 In ACCUM with iEn=1, each ones-counter (BITWIDTH+1 bits) SHALL increment when its stream bit is 1, and the cycle counter SHALL increment.
REQ-015 In ACCUM with iEn=0, all counters SHALL hold.
REQ-016 When the N-th enabled sample is counted, the FSM SHALL enter DONE, assert oValid the next cycle, and register the outputs.
REQ-017 Output arithmetic: each output SHALL be its count saturated to 2^BITWIDTH-1, so a count of N is reported as N-1.
REQ-018 In DONE, oValid and the outputs SHALL hold stable until iReady=1; DONE -> IDLE SHALL occur on the edge where oValid=1 and iReady=1.
REQ-019 iStart SHALL be ignored in ACCUM and DONE, including the same cycle as the DONE handshake.
REQ-020 iClr=1 SHALL force IDLE from any state, zero all counters, drop oValid and zero the outputs; iClr takes priority over iStart, iEn and iReady.
REQ-021 oBusy SHALL be 1 exactly while the state is ACCUM.
REQ-022 Outputs SHALL be register-driven with no combinational path from any input.

Reset
REQ-023 iRst=1 SHALL immediately force IDLE, set oBusy=0 and oValid=0, and zero all outputs and counters, including in the middle of a window.
REQ-024 After reset is released, the block SHALL wait for a fresh iStart; a partially accumulated window SHALL NOT resume.

Verification (BITWIDTH=4, N=16)
REQ-025 iStart, then 16 cycles with iEn=1 and all streams =1 -> oValid=1 one cycle after the 16th sample, all outputs =15 (saturated).
REQ-026 Per 16-sample window: iReal0 alternating 1/0, iImg0=0, iReal1 at 4 ones, iImg1 at 12 ones -> outputs 8, 0, 4, 12.
REQ-027 Same stimulus as REQ-026 with iEn=0 on 5 cycles interleaved -> identical results; oValid delayed 5 cycles; oBusy high for 21 cycles.
REQ-028 Hold iReady=0 for 10 cycles in DONE while pulsing iStart and toggling streams -> outputs and oValid unchanged; a single iReady pulse returns the FSM to IDLE.
REQ-029 Assert iRst asynchronously at sample 7 (also repeat the test with iClr) -> oBusy=0 and outputs =0 immediately; the next full window of all-zero streams yields outputs 0.
